// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a pending-write scoreboard.
// NUM_RD combinational operand ports with write-to-read bypass, one debug
// port without bypass, one write port, and a busy bit per register that is
// set on issue and cleared on write-back.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    output logic [NUM_RD-1:0]          read_busy,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_reg,
    input  logic [ADDR_W-1:0]          Input_Readreg,
    output logic [DATA_W-1:0]          RegOut,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_ok;
    logic              iss_ok;
    logic              dbg_zero;

    // A write or issue aimed at the hardwired zero register is dropped
    // entirely, so r0 never holds data and never goes busy.
    assign wr_ok  = reg_write   && !((ZERO_REG != 0) && (write_reg == '0));
    assign iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_reg == '0));

    // Scoreboard next state: write-back clears, issue sets; applying the
    // issue last makes it win when both target the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[write_reg] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[issue_reg] = 1'b1;
        end
    end

    // Storage and busy flops; reset wipes both and masks same-cycle traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                regs[n] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs[write_reg] <= write_data;
            end
            busy_q <= busy_d;
        end
    end

    // Operand read ports: zero register, then the retiring write, then storage.
    // A same-cycle issue is deliberately invisible here.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit;

        assign addr    = read_reg[g*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = wr_ok && (write_reg == addr);

        assign read_data[g*DATA_W +: DATA_W] = is_zero ? '0 :
                                               hit     ? write_data :
                                                         regs[addr];
        assign read_busy[g] = is_zero ? 1'b0 :
                              hit     ? 1'b0 :
                                        busy_q[addr];
    end

    // Debug port sees committed storage only.
    assign dbg_zero = (ZERO_REG != 0) && (Input_Readreg == '0);
    assign RegOut   = dbg_zero ? '0 : regs[Input_Readreg];
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default configuration,
// a ZERO_REG=0 instance, and a narrow 4-port instance.
module tb_regfile_sb;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // instance A: defaults (32b, 32 regs, 2 ports, zero reg)
    logic          a_reg_write;
    logic [4:0]    a_write_reg;
    logic [31:0]   a_write_data;
    logic [9:0]    a_read_reg;
    logic [63:0]   a_read_data;
    logic [1:0]    a_read_busy;
    logic          a_issue_valid;
    logic [4:0]    a_issue_reg;
    logic [4:0]    a_dbg_addr;
    logic [31:0]   a_reg_out;
    logic [31:0]   a_busy_vec;

    // instance B: no zero register
    logic          b_reg_write;
    logic [4:0]    b_write_reg;
    logic [31:0]   b_write_data;
    logic [9:0]    b_read_reg;
    logic [63:0]   b_read_data;
    logic [1:0]    b_read_busy;
    logic          b_issue_valid;
    logic [4:0]    b_issue_reg;
    logic [4:0]    b_dbg_addr;
    logic [31:0]   b_reg_out;
    logic [31:0]   b_busy_vec;

    // instance C: 16b data, 8 regs, 4 ports
    logic          c_reg_write;
    logic [2:0]    c_write_reg;
    logic [15:0]   c_write_data;
    logic [11:0]   c_read_reg;
    logic [63:0]   c_read_data;
    logic [3:0]    c_read_busy;
    logic          c_issue_valid;
    logic [2:0]    c_issue_reg;
    logic [2:0]    c_dbg_addr;
    logic [15:0]   c_reg_out;
    logic [7:0]    c_busy_vec;

    regfile_sb u_a (
        .clk(clk), .reset(reset),
        .reg_write(a_reg_write), .write_reg(a_write_reg), .write_data(a_write_data),
        .read_reg(a_read_reg), .read_data(a_read_data), .read_busy(a_read_busy),
        .issue_valid(a_issue_valid), .issue_reg(a_issue_reg),
        .Input_Readreg(a_dbg_addr), .RegOut(a_reg_out), .busy_vec(a_busy_vec)
    );

    regfile_sb #(.ZERO_REG(0)) u_b (
        .clk(clk), .reset(reset),
        .reg_write(b_reg_write), .write_reg(b_write_reg), .write_data(b_write_data),
        .read_reg(b_read_reg), .read_data(b_read_data), .read_busy(b_read_busy),
        .issue_valid(b_issue_valid), .issue_reg(b_issue_reg),
        .Input_Readreg(b_dbg_addr), .RegOut(b_reg_out), .busy_vec(b_busy_vec)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_c (
        .clk(clk), .reset(reset),
        .reg_write(c_reg_write), .write_reg(c_write_reg), .write_data(c_write_data),
        .read_reg(c_read_reg), .read_data(c_read_data), .read_busy(c_read_busy),
        .issue_valid(c_issue_valid), .issue_reg(c_issue_reg),
        .Input_Readreg(c_dbg_addr), .RegOut(c_reg_out), .busy_vec(c_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past the next rising edge; inputs then change 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        a_dbg_addr = 5'd5;
        a_read_reg = {5'd7, 5'd5};
        #1;
        checks++;
        if (a_busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_busy got %h exp %h", a_busy_vec, 32'h0);
        end
        checks++;
        if (a_read_data !== 64'h0 || a_reg_out !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0", a_read_data, a_reg_out);
        end
        // preload r5 and a pending r7, then reset again
        a_reg_write = 1'b1; a_write_reg = 5'd5; a_write_data = 32'hDEADBEEF;
        a_issue_valid = 1'b1; a_issue_reg = 5'd7;
        tick();
        a_reg_write = 1'b0; a_issue_valid = 1'b0;
        #1;
        checks++;
        if (a_reg_out !== 32'hDEADBEEF || a_busy_vec[7] !== 1'b1) begin
            errors++; $display("FAIL preload got %h busy7 %b exp deadbeef 1", a_reg_out, a_busy_vec[7]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (a_read_data[31:0] !== 32'h0 || a_reg_out !== 32'h0 || a_busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_preloaded got %h %h %h exp 0", a_read_data[31:0], a_reg_out, a_busy_vec);
        end
    endtask

    task automatic test_bypass();
        a_reg_write = 1'b1; a_write_reg = 5'd3; a_write_data = 32'h11111111;
        tick();
        a_write_data = 32'h12345678;
        a_read_reg = {5'd3, 5'd0};
        a_dbg_addr = 5'd3;
        #1;
        checks++;
        if (a_read_data[63:32] !== 32'h12345678 || a_read_busy[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_read got %h busy %b exp 12345678 0", a_read_data[63:32], a_read_busy[1]);
        end
        checks++;
        if (a_reg_out !== 32'h11111111) begin
            errors++; $display("FAIL bypass_debug_old got %h exp %h", a_reg_out, 32'h11111111);
        end
        tick();
        a_reg_write = 1'b0;
        #1;
        checks++;
        if (a_reg_out !== 32'h12345678 || a_read_data[63:32] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_commit got %h/%h exp 12345678", a_reg_out, a_read_data[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        a_reg_write = 1'b1; a_write_reg = 5'd0; a_write_data = 32'hFFFFFFFF;
        a_issue_valid = 1'b1; a_issue_reg = 5'd0;
        a_read_reg = 10'd0; a_dbg_addr = 5'd0;
        b_reg_write = 1'b1; b_write_reg = 5'd0; b_write_data = 32'hFFFFFFFF;
        b_issue_valid = 1'b1; b_issue_reg = 5'd0;
        b_read_reg = 10'd0; b_dbg_addr = 5'd0;
        #1;
        checks++;
        if (a_read_data[31:0] !== 32'h0 || b_read_data[31:0] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL zero_bypass got a=%h b=%h exp 0 ffffffff", a_read_data[31:0], b_read_data[31:0]);
        end
        tick();
        a_reg_write = 1'b0; a_issue_valid = 1'b0;
        b_reg_write = 1'b0; b_issue_valid = 1'b0;
        #1;
        checks++;
        if (a_read_data[31:0] !== 32'h0 || a_reg_out !== 32'h0 || a_busy_vec[0] !== 1'b0 || a_read_busy[0] !== 1'b0) begin
            errors++; $display("FAIL zero_hardwired got %h %h %b %b exp 0", a_read_data[31:0], a_reg_out, a_busy_vec[0], a_read_busy[0]);
        end
        checks++;
        if (b_read_data[31:0] !== 32'hFFFFFFFF || b_reg_out !== 32'hFFFFFFFF || b_busy_vec[0] !== 1'b1) begin
            errors++; $display("FAIL zero_disabled got %h %h %b exp ffffffff ffffffff 1", b_read_data[31:0], b_reg_out, b_busy_vec[0]);
        end
    endtask

    task automatic test_scoreboard();
        a_issue_valid = 1'b1; a_issue_reg = 5'd9;
        a_read_reg = {5'd0, 5'd9};
        #1;
        checks++;
        if (a_read_busy[0] !== 1'b0) begin
            errors++; $display("FAIL issue_not_yet got %b exp 0", a_read_busy[0]);
        end
        tick();
        a_issue_valid = 1'b0;
        #1;
        checks++;
        if (a_read_busy[0] !== 1'b1 || a_busy_vec[9] !== 1'b1) begin
            errors++; $display("FAIL issue_busy got %b/%b exp 1", a_read_busy[0], a_busy_vec[9]);
        end
        a_reg_write = 1'b1; a_write_reg = 5'd9; a_write_data = 32'hA5;
        #1;
        checks++;
        if (a_read_busy[0] !== 1'b0 || a_read_data[31:0] !== 32'hA5 || a_busy_vec[9] !== 1'b1) begin
            errors++; $display("FAIL wb_bypass got busy %b data %h vec %b exp 0 a5 1", a_read_busy[0], a_read_data[31:0], a_busy_vec[9]);
        end
        tick();
        a_reg_write = 1'b0;
        #1;
        checks++;
        if (a_busy_vec[9] !== 1'b0 || a_read_data[31:0] !== 32'hA5) begin
            errors++; $display("FAIL wb_commit got vec %b data %h exp 0 a5", a_busy_vec[9], a_read_data[31:0]);
        end
    endtask

    task automatic test_write_issue_same();
        a_reg_write = 1'b1; a_write_reg = 5'd4; a_write_data = 32'h44;
        a_issue_valid = 1'b1; a_issue_reg = 5'd4;
        tick();
        a_reg_write = 1'b0;
        a_issue_reg = 5'd10;
        a_read_reg = {5'd0, 5'd4};
        #1;
        checks++;
        if (a_busy_vec[4] !== 1'b1 || a_read_data[31:0] !== 32'h44 || a_read_busy[0] !== 1'b1) begin
            errors++; $display("FAIL same_reg got vec %b data %h busy %b exp 1 44 1", a_busy_vec[4], a_read_data[31:0], a_read_busy[0]);
        end
        tick();
        a_reg_write = 1'b1; a_write_reg = 5'd10; a_write_data = 32'h10;
        a_issue_reg = 5'd11;
        tick();
        a_reg_write = 1'b0; a_issue_valid = 1'b0;
        #1;
        checks++;
        if (a_busy_vec[10] !== 1'b0 || a_busy_vec[11] !== 1'b1) begin
            errors++; $display("FAIL diff_regs got b10 %b b11 %b exp 0 1", a_busy_vec[10], a_busy_vec[11]);
        end
    endtask

    task automatic test_reset_midstream();
        reset = 1'b1;
        a_reg_write = 1'b1; a_write_reg = 5'd12; a_write_data = 32'h99;
        a_issue_valid = 1'b1; a_issue_reg = 5'd12;
        tick();
        reset = 1'b0;
        a_reg_write = 1'b0; a_issue_valid = 1'b0;
        a_dbg_addr = 5'd12;
        #1;
        checks++;
        if (a_busy_vec !== 32'h0 || a_reg_out !== 32'h0) begin
            errors++; $display("FAIL mid_reset got vec %h r12 %h exp 0 0", a_busy_vec, a_reg_out);
        end
        a_reg_write = 1'b1; a_write_reg = 5'd11; a_write_data = 32'h77;
        tick();
        a_reg_write = 1'b0;
        a_read_reg = {5'd0, 5'd11};
        a_dbg_addr = 5'd11;
        #1;
        checks++;
        if (a_read_data[31:0] !== 32'h77 || a_read_busy[0] !== 1'b0 || a_reg_out !== 32'h77) begin
            errors++; $display("FAIL post_reset_write got %h busy %b dbg %h exp 77 0 77", a_read_data[31:0], a_read_busy[0], a_reg_out);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_val;
        for (int n = 0; n < 8; n++) begin
            c_reg_write = 1'b1;
            c_write_reg = 3'(n);
            c_write_data = 16'(n) * 16'h1111;
            tick();
        end
        c_reg_write = 1'b0;
        for (int base = 0; base < 8; base += 4) begin
            for (int i = 0; i < 4; i++) begin
                c_read_reg[i*3 +: 3] = 3'(base + i);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                exp_val = 16'(base + i) * 16'h1111;
                checks++;
                if (c_read_data[i*16 +: 16] !== exp_val) begin
                    errors++; $display("FAIL sweep_port%0d_r%0d got %h exp %h", i, base + i, c_read_data[i*16 +: 16], exp_val);
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            c_dbg_addr = 3'(n);
            #1;
            exp_val = 16'(n) * 16'h1111;
            checks++;
            if (c_reg_out !== exp_val) begin
                errors++; $display("FAIL sweep_debug_r%0d got %h exp %h", n, c_reg_out, exp_val);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        a_reg_write = 1'b0; a_write_reg = '0; a_write_data = '0; a_read_reg = '0;
        a_issue_valid = 1'b0; a_issue_reg = '0; a_dbg_addr = '0;
        b_reg_write = 1'b0; b_write_reg = '0; b_write_data = '0; b_read_reg = '0;
        b_issue_valid = 1'b0; b_issue_reg = '0; b_dbg_addr = '0;
        c_reg_write = 1'b0; c_write_reg = '0; c_write_data = '0; c_read_reg = '0;
        c_issue_valid = 1'b0; c_issue_reg = '0; c_dbg_addr = '0;

        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_write_issue_same();
        test_reset_midstream();
        test_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
